// File: rtl/counter_arbiter_pkg.sv
// Shared definitions for the counter arbiter: operation encoding and
// round-robin index stepping.
package counter_arbiter_pkg;

   localparam logic OP_INC = 1'b0;
   localparam logic OP_DEC = 1'b1;

   // Next round-robin index after idx, wrapping explicitly at n-1 so
   // non-power-of-two requester counts never step onto an unused index.
   function automatic int rr_next(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/counter_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches from the pointer upward with wrap and
// picks the first active request. The pointer moves past the winner only
// when the parent says the grant was actually issued.
module rr_arbiter
   import counter_arbiter_pkg::*;
#(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic                 advance,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] idx,
   output logic                 valid
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] ptr;

   // Wrapping priority search starting at the pointer.
   always_comb begin
      int cand;
      valid = 1'b0;
      idx   = ptr;
      for (int k = 0; k < N; k++) begin
         cand = int'(ptr) + k;
         if (cand >= N) cand = cand - N;
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = IW'(cand);
         end
      end
      gnt = valid ? (N'(1) << idx) : '0;
   end

   // Pointer steps past the winner on every issued grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         ptr <= '0;
      else if (advance)
         ptr <= IW'(rr_next(int'(idx), N));
   end

endmodule

// File: rtl/counter_arbiter.sv
// Shared up/down count register served to N requesters in round-robin
// order. Grant and nack are combinational; the count saturates at 0 and
// MAX_VAL and never wraps.
module counter_arbiter
   import counter_arbiter_pkg::*;
#(
   parameter int N       = 4,
   parameter int W       = 8,
   parameter int MAX_VAL = 2**W - 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         op,
   input  logic                 clr,
   output logic [N-1:0]         gnt,
   output logic                 nack,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic [W-1:0]         count,
   output logic                 full,
   output logic                 empty
);

   localparam int          IW    = $clog2(N);
   localparam logic [W-1:0] MAX_C = W'(MAX_VAL);

   logic [N-1:0]  arb_gnt;
   logic [IW-1:0] arb_idx;
   logic          arb_valid;
   logic          active;
   logic          op_sel;
   logic          at_bound;

   rr_arbiter #(.N(N)) u_rr (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .advance (active),
      .gnt     (arb_gnt),
      .idx     (arb_idx),
      .valid   (arb_valid)
   );

   // Qualify the raw arbiter choice with reset and clear, then bounds-check it.
   always_comb begin
      op_sel   = op[arb_idx];
      active   = rst && !clr && arb_valid;
      at_bound = (op_sel == OP_INC) ? (count == MAX_C) : (count == '0);
      nack     = active && at_bound;
      gnt      = active ? arb_gnt : '0;
   end

   // Count register: clear wins, otherwise apply an accepted grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (active && !at_bound) begin
         if (op_sel == OP_INC)
            count <= count + W'(1);
         else
            count <= count - W'(1);
      end
   end

   // Last granted index, updated on nacked grants too.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         gnt_id <= '0;
      else if (active)
         gnt_id <= arb_idx;
   end

   assign full  = (count == MAX_C);
   assign empty = (count == '0);

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with N=4, W=4, MAX_VAL=10.
module tb_counter_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] op;
   logic       clr;
   logic [3:0] gnt;
   logic       nack;
   logic [1:0] gnt_id;
   logic [3:0] count;
   logic       full;
   logic       empty;

   int n_cmp;
   int n_err;

   counter_arbiter #(.N(4), .W(4), .MAX_VAL(10)) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .op     (op),
      .clr    (clr),
      .gnt    (gnt),
      .nack   (nack),
      .gnt_id (gnt_id),
      .count  (count),
      .full   (full),
      .empty  (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b0; req = 4'b0000; op = 4'b0000; clr = 1'b0;
      #12;
      chk("rst_count", count, 0);
      chk("rst_gnt_id", gnt_id, 0);
      chk("rst_full", full, 0);
      chk("rst_empty", empty, 1);
      req = 4'b1111;
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_nack", nack, 0);

      // Rotation through all four requesters
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rot_gnt", gnt, 1 << k);
         chk("rot_nack", nack, 0);
         tick();
         chk("rot_gnt_id", gnt_id, k);
         chk("rot_count", count, k + 1);
      end

      // Fill to MAX_VAL using requester 0 only
      req = 4'b0001; op = 4'b0000;
      for (int k = 0; k < 6; k++) tick();
      chk("fill_count", count, 10);
      chk("fill_full", full, 1);

      // Increment at full is nacked; pointer still moves to 3
      req = 4'b0100; op = 4'b0000;
      #1;
      chk("full_gnt", gnt, 4'b0100);
      chk("full_nack", nack, 1);
      tick();
      chk("full_count", count, 10);
      chk("full_gnt_id", gnt_id, 2);
      req = 4'b1111; op = 4'b1111;
      #1;
      chk("ptr3_gnt", gnt, 4'b1000);
      chk("ptr3_nack", nack, 0);
      tick();
      chk("dec_count", count, 9);
      chk("dec_full", full, 0);

      // Drain to zero, then a decrement must be nacked with no wrap
      req = 4'b0010;
      for (int k = 0; k < 9; k++) tick();
      chk("drain_count", count, 0);
      chk("drain_empty", empty, 1);
      #1;
      chk("empty_gnt", gnt, 4'b0010);
      chk("empty_nack", nack, 1);
      tick();
      chk("empty_count", count, 0);
      chk("empty_gnt_id", gnt_id, 1);

      // Up to 5, then clear with pending requests
      req = 4'b0001; op = 4'b0000;
      for (int k = 0; k < 5; k++) tick();
      chk("pre_clr_count", count, 5);
      clr = 1'b1; req = 4'b0011;
      #1;
      chk("clr_gnt", gnt, 0);
      chk("clr_nack", nack, 0);
      tick();
      chk("clr_count", count, 0);
      chk("clr_gnt_id", gnt_id, 0);
      clr = 1'b0;
      #1;
      chk("post_clr_gnt", gnt, 4'b0010);
      tick();
      chk("post_clr_count", count, 1);

      // Put pointer at 3, then alternate between requesters 0 and 2
      req = 4'b0100;
      tick();
      chk("ptr_set_count", count, 2);
      req = 4'b0101;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("alt_gnt", gnt, (k % 2 == 0) ? 4'b0001 : 4'b0100);
         tick();
      end
      chk("alt_count", count, 6);
      req = 4'b1000;
      tick();
      chk("pre_rst_count", count, 7);
      chk("pre_rst_empty", empty, 0);

      // Asynchronous reset mid-cycle
      req = 4'b1111;
      #2;
      rst = 1'b0;
      #1;
      chk("arst_count", count, 0);
      chk("arst_gnt", gnt, 0);
      chk("arst_gnt_id", gnt_id, 0);
      chk("arst_empty", empty, 1);
      @(negedge clk);
      rst = 1'b1;
      req = 4'b1000; op = 4'b0000;
      #1;
      chk("rel_gnt", gnt, 4'b1000);
      tick();
      chk("rel_count", count, 1);
      chk("rel_gnt_id", gnt_id, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
